// File: rtl/m3_dequant_zz.sv
// Dequantizer and zigzag-to-row-major writer for one 8x8 coefficient block.
// Optional macro M3DQ_SAT_EN: saturate instead of wrap when the shifted value overflows COEF_W.
module m3_dequant_zz #(
    parameter int IN_W   = 9,
    parameter int COEF_W = 16,
    parameter int RAM_AW = 7,
    parameter int BASE   = 0
) (
    input  logic                   CLOCK_50_I,
    input  logic                   Reset,
    input  logic                   blk_start,
    input  logic                   q_sel,
    input  logic                   coef_valid,
    input  logic signed [IN_W-1:0] coef_value,
    input  logic [5:0]             coef_run,
    input  logic                   coef_eob,
    output logic                   coef_ready,
    output logic [RAM_AW-1:0]      ram_address,
    output logic [31:0]            ram_write_data,
    output logic                   ram_we,
    output logic                   busy,
    output logic                   blk_done,
    output logic                   err
);

    localparam int WIDE_W = ((IN_W + 6 > COEF_W) ? IN_W + 6 : COEF_W) + 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ZERO,
        WRITE,
        FILL,
        DONE
    } state_t;

    // Row-major position of each zigzag index.
    localparam logic [5:0] ZZ_POS [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Shift per diagonal (row + column); entry 15 is unreachable padding.
    localparam logic [2:0] SHIFT_Q0 [0:15] = '{
        3'd3, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5,
        3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd0
    };
    localparam logic [2:0] SHIFT_Q1 [0:15] = '{
        3'd3, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3,
        3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd5, 3'd5, 3'd0
    };

    state_t                 state_reg, state_next;
    logic [5:0]             k_reg, k_next;
    logic [5:0]             run_reg, run_next;
    logic signed [IN_W-1:0] value_reg, value_next;
    logic                   q_sel_reg, q_sel_next;
    logic                   err_reg, err_next;

    logic                   coef_ready_reg;
    logic                   ram_we_reg;
    logic                   busy_reg;
    logic                   blk_done_reg;
    logic [RAM_AW-1:0]      ram_address_reg;
    logic [31:0]            ram_write_data_reg;

    logic [2:0]             shift_sel [0:15];
    logic [5:0]             pos_next;
    logic [3:0]             diag_next;
    logic [2:0]             shift_next;
    logic [RAM_AW-1:0]      addr_next;
    logic signed [WIDE_W-1:0] value_ext;
    logic signed [COEF_W-1:0] coef_res;
    logic [31:0]            data_next;
    logic                   we_next;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_shift
            assign shift_sel[gi] = q_sel_next ? SHIFT_Q1[gi] : SHIFT_Q0[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        run_next   = run_reg;
        value_next = value_reg;
        q_sel_next = q_sel_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (blk_start) begin
                    state_next = WAIT;
                    k_next     = 6'd0;
                    err_next   = 1'b0;
                    q_sel_next = q_sel;
                end
            end
            WAIT: begin
                if (coef_valid) begin
                    if (coef_eob) begin
                        state_next = FILL;
                    end else begin
                        value_next = coef_value;
                        run_next   = coef_run;
                        state_next = (coef_run != 6'd0) ? ZERO : WRITE;
                    end
                end
            end
            ZERO: begin
                k_next   = k_reg + 6'd1;
                run_next = run_reg - 6'd1;
                // A zero landing on 63 leaves no slot for the pending value.
                if (k_reg == 6'd63) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end else if (run_reg == 6'd1) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                k_next     = k_reg + 6'd1;
                state_next = (k_reg == 6'd63) ? DONE : WAIT;
            end
            FILL: begin
                k_next = k_reg + 6'd1;
                if (k_reg == 6'd63) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are precomputed from the next state so the write lands in the
    // same cycle the state register shows the writing state.
    always_comb begin
        pos_next   = ZZ_POS[k_next];
        diag_next  = {1'b0, pos_next[5:3]} + {1'b0, pos_next[2:0]};
        shift_next = shift_sel[diag_next];
        addr_next  = RAM_AW'(BASE) + RAM_AW'(pos_next);
        value_ext  = WIDE_W'(value_next);
`ifdef M3DQ_SAT_EN
        begin
            logic signed [WIDE_W-1:0] wide_shl;
            logic signed [WIDE_W-1:0] wide_max;
            logic signed [WIDE_W-1:0] wide_min;
            wide_shl = value_ext <<< shift_next;
            wide_max = {{(WIDE_W-COEF_W+1){1'b0}}, {(COEF_W-1){1'b1}}};
            wide_min = {{(WIDE_W-COEF_W+1){1'b1}}, {(COEF_W-1){1'b0}}};
            if (wide_shl > wide_max) begin
                coef_res = wide_max[COEF_W-1:0];
            end else if (wide_shl < wide_min) begin
                coef_res = wide_min[COEF_W-1:0];
            end else begin
                coef_res = wide_shl[COEF_W-1:0];
            end
        end
`else
        coef_res = COEF_W'(value_ext <<< shift_next);
`endif
        we_next   = (state_next == ZERO) || (state_next == WRITE) || (state_next == FILL);
        data_next = (state_next == WRITE) ? 32'(coef_res) : 32'd0;
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) begin
            state_reg          <= IDLE;
            k_reg              <= 6'd0;
            run_reg            <= 6'd0;
            value_reg          <= '0;
            q_sel_reg          <= 1'b0;
            err_reg            <= 1'b0;
            coef_ready_reg     <= 1'b0;
            ram_we_reg         <= 1'b0;
            busy_reg           <= 1'b0;
            blk_done_reg       <= 1'b0;
            ram_address_reg    <= '0;
            ram_write_data_reg <= 32'd0;
        end else begin
            state_reg          <= state_next;
            k_reg              <= k_next;
            run_reg            <= run_next;
            value_reg          <= value_next;
            q_sel_reg          <= q_sel_next;
            err_reg            <= err_next;
            coef_ready_reg     <= (state_next == WAIT);
            ram_we_reg         <= we_next;
            busy_reg           <= (state_next != IDLE);
            blk_done_reg       <= (state_next == DONE);
            ram_address_reg    <= we_next ? addr_next : '0;
            ram_write_data_reg <= data_next;
        end
    end

    assign coef_ready     = coef_ready_reg;
    assign ram_we         = ram_we_reg;
    assign busy           = busy_reg;
    assign blk_done       = blk_done_reg;
    assign err            = err_reg;
    assign ram_address    = ram_address_reg;
    assign ram_write_data = ram_write_data_reg;

endmodule

// File: tb/tb_m3_dequant_zz.sv
// Scoreboard bench for m3_dequant_zz: a token-level model queues expected RAM writes.
module tb_m3_dequant_zz;

    localparam int IN_W   = 9;
    localparam int COEF_W = 12;
    localparam int RAM_AW = 7;
    localparam int BASE   = 64;
    localparam int LIM    = 1 << (COEF_W - 1);
`ifdef M3DQ_SAT_EN
    localparam logic [31:0] SAT_EXP = 32'h0000_07FF;
`else
    localparam logic [31:0] SAT_EXP = 32'hFFFF_FFC0;
`endif

    logic                   clk;
    logic                   Reset;
    logic                   blk_start;
    logic                   q_sel;
    logic                   coef_valid;
    logic signed [IN_W-1:0] coef_value;
    logic [5:0]             coef_run;
    logic                   coef_eob;
    logic                   coef_ready;
    logic [RAM_AW-1:0]      ram_address;
    logic [31:0]            ram_write_data;
    logic                   ram_we;
    logic                   busy;
    logic                   blk_done;
    logic                   err;

    m3_dequant_zz #(
        .IN_W(IN_W), .COEF_W(COEF_W), .RAM_AW(RAM_AW), .BASE(BASE)
    ) dut (
        .CLOCK_50_I(clk), .Reset(Reset), .blk_start(blk_start), .q_sel(q_sel),
        .coef_valid(coef_valid), .coef_value(coef_value), .coef_run(coef_run),
        .coef_eob(coef_eob), .coef_ready(coef_ready), .ram_address(ram_address),
        .ram_write_data(ram_write_data), .ram_we(ram_we), .busy(busy),
        .blk_done(blk_done), .err(err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [RAM_AW-1:0] a;
        logic [31:0]       d;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          zz_pos[64];
    int          sh0[15] = '{3, 2, 3, 3, 4, 4, 5, 5, 6, 6, 6, 6, 6, 6, 6};
    int          sh1[15] = '{3, 1, 1, 1, 2, 2, 3, 3, 4, 4, 4, 5, 5, 5, 5};
    int          m_k = 0;
    bit          m_q = 0;
    bit          m_err = 0;
    logic [31:0] last_data = 32'd0;

    // Zigzag order derived by walking anti-diagonals, alternating direction.
    task automatic build_zz();
        int idx = 0;
        for (int d = 0; d < 15; d++) begin
            int lo = (d > 7) ? d - 7 : 0;
            int hi = (d < 7) ? d : 7;
            if (d % 2 == 1) begin
                for (int r = lo; r <= hi; r++) begin zz_pos[idx] = r * 8 + (d - r); idx++; end
            end else begin
                for (int r = hi; r >= lo; r--) begin zz_pos[idx] = r * 8 + (d - r); idx++; end
            end
        end
    endtask

    function automatic logic [31:0] exp_deq(int v, int k, bit q);
        int pos = zz_pos[k];
        int d = pos / 8 + pos % 8;
        int sh = q ? sh1[d] : sh0[d];
        int x = v * (1 << sh);
`ifdef M3DQ_SAT_EN
        if (x > LIM - 1) x = LIM - 1;
        else if (x < -LIM) x = -LIM;
`else
        x = x & (2 * LIM - 1);
        if (x >= LIM) x = x - 2 * LIM;
`endif
        return x;
    endfunction

    task automatic push_exp(int k, logic [31:0] d);
        exp_t e;
        e.a = RAM_AW'(BASE + zz_pos[k]);
        e.d = d;
        sbq.push_back(e);
    endtask

    task automatic model_token(int v, int run, bit eob);
        bit ovf = 0;
        if (eob) begin
            while (m_k < 64) begin push_exp(m_k, 32'd0); m_k++; end
        end else begin
            for (int i = 0; i < run && !ovf; i++) begin
                push_exp(m_k, 32'd0);
                m_k++;
                if (m_k == 64) begin ovf = 1; m_err = 1; end
            end
            if (!ovf) begin push_exp(m_k, exp_deq(v, m_k, m_q)); m_k++; end
        end
    endtask

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected addr=%0d data=%h", ram_address, ram_write_data);
            end else begin
                mon_e = sbq.pop_front();
                if (ram_address !== mon_e.a || ram_write_data !== mon_e.d) begin
                    bad++;
                    $display("FAIL write got addr=%0d data=%h required addr=%0d data=%h",
                             ram_address, ram_write_data, mon_e.a, mon_e.d);
                end
            end
            last_data = ram_write_data;
        end
    end

    task automatic start_block(bit q);
        int guard = 0;
        while (busy !== 1'b0 && guard < 200) begin @(posedge clk); #1; guard++; end
        blk_start = 1'b1;
        q_sel     = q;
        @(posedge clk); #1;
        blk_start = 1'b0;
        m_k = 0; m_q = q; m_err = 0;
        total++;
        if (busy !== 1'b1 || coef_ready !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL start busy=%b ready=%b err=%b required 1 1 0", busy, coef_ready, err);
        end
    endtask

    task automatic send_token(int v, int run, bit eob, output int stalls);
        model_token(v, run, eob);
        coef_valid = 1'b1;
        coef_value = IN_W'(v);
        coef_run   = 6'(run);
        coef_eob   = eob;
        stalls = 0;
        while (coef_ready !== 1'b1 && stalls < 300) begin @(posedge clk); #1; stalls++; end
        total++;
        if (coef_ready !== 1'b1) begin
            bad++;
            $display("FAIL token_timeout ready=%b required 1", coef_ready);
        end
        @(posedge clk); #1;
        coef_valid = 1'b0;
        $display("token v=%0d run=%0d eob=%0d k_after=%0d stalls=%0d", v, run, eob, m_k, stalls);
    endtask

    task automatic wait_done(string name);
        int guard = 0;
        while (blk_done !== 1'b1 && guard < 400) begin @(posedge clk); #1; guard++; end
        total++;
        if (blk_done !== 1'b1) begin bad++; $display("FAIL %s_done_timeout blk_done=%b required 1", name, blk_done); end
        total++;
        if (sbq.size() != 0) begin bad++; $display("FAIL %s_pending_writes got=%0d required 0", name, sbq.size()); end
        total++;
        if (err !== m_err) begin bad++; $display("FAIL %s_err got=%b required %b", name, err, m_err); end
        @(posedge clk); #1;
        total++;
        if (blk_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_done_pulse blk_done=%b busy=%b required 0 0", name, blk_done, busy);
        end
        $display("block %s done err=%b", name, err);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({coef_ready, ram_we, busy, blk_done, err} !== 5'b0 || ram_address !== '0 || ram_write_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_state ready=%b we=%b busy=%b done=%b err=%b addr=%0d data=%h required all 0",
                     coef_ready, ram_we, busy, blk_done, err, ram_address, ram_write_data);
        end
        Reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int s;
        start_block(0);
        send_token(5, 0, 0, s);
        total++;
        if (ram_we !== 1'b1 || ram_write_data !== 32'd40 || ram_address !== 7'(BASE)) begin
            bad++;
            $display("FAIL single_first_write we=%b addr=%0d data=%h required 1 %0d 40", ram_we, ram_address, ram_write_data, BASE);
        end
        send_token(0, 0, 1, s);
        wait_done("single");
    endtask

    task automatic test_runs_sign();
        int s;
        start_block(1);
        send_token(-3, 0, 0, s);
        blk_start = 1'b1;
        q_sel     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        blk_start = 1'b0;
        send_token(7, 2, 0, s);
        send_token(0, 0, 1, s);
        wait_done("runs_sign");
    endtask

    task automatic test_overflow();
        int s;
        start_block(0);
        send_token(1, 0, 0, s);
        send_token(9, 63, 0, s);
        wait_done("overflow");
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL overflow_err_hold got=%b required 1", err); end
        start_block(0);
        send_token(0, 0, 1, s);
        wait_done("after_overflow");
    endtask

    task automatic test_saturation();
        int s;
        start_block(0);
        send_token(0, 62, 0, s);
        send_token(255, 0, 0, s);
        wait_done("saturation");
        total++;
        if (last_data !== SAT_EXP) begin bad++; $display("FAIL sat_k63 got=%h required %h", last_data, SAT_EXP); end
    endtask

    task automatic test_back_to_back();
        int s;
        start_block(0);
        send_token(4, 5, 0, s);
        send_token(6, 0, 0, s);
        total++;
        if (s != 6) begin bad++; $display("FAIL backpressure_stalls got=%0d required 6", s); end
        send_token(0, 0, 1, s);
        wait_done("back_to_back");
    endtask

    task automatic test_reset_mid();
        int s;
        int cnt = 0;
        int guard = 0;
        start_block(0);
        send_token(2, 30, 0, s);
        while (guard < 100) begin
            if (ram_we === 1'b1) cnt++;
            if (cnt == 10) break;
            @(posedge clk); #1;
            guard++;
        end
        Reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if (ram_we !== 1'b0 || busy !== 1'b0 || cnt != 10) begin
            bad++;
            $display("FAIL reset_mid we=%b busy=%b writes=%0d required 0 0 10", ram_we, busy, cnt);
        end
        sbq.delete();
        Reset = 1'b0;
        @(posedge clk); #1;
        start_block(0);
        send_token(1, 0, 0, s);
        total++;
        if (ram_address !== 7'(BASE) || ram_write_data !== 32'd8) begin
            bad++;
            $display("FAIL reset_restart addr=%0d data=%h required %0d 8", ram_address, ram_write_data, BASE);
        end
        send_token(0, 0, 1, s);
        wait_done("reset_restart");
    endtask

    task automatic test_random();
        int s;
        for (int b = 0; b < 3; b++) begin
            start_block(b[0]);
            while (m_k < 64) begin
                send_token(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 6)),
                           ($urandom_range(0, 9) == 0), s);
            end
            wait_done("random");
        end
    endtask

    initial begin
        Reset      = 1'b1;
        blk_start  = 1'b0;
        q_sel      = 1'b0;
        coef_valid = 1'b0;
        coef_value = '0;
        coef_run   = 6'd0;
        coef_eob   = 1'b0;
        build_zz();
        test_reset();
        test_single();
        test_runs_sign();
        test_overflow();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m3_dequant_zz.md
M3_DEQUANT_ZZ -- requirements
Module: m3_dequant_zz

Interface
REQ-001 SHALL have parameter IN_W, default 9, signed width of incoming quantized coefficient.
REQ-002 SHALL have parameter COEF_W, default 16, signed width of dequantized coefficient before sign extension to 32 bits.
REQ-003 SHALL have parameter RAM_AW, default 7, DPRAM address width.
REQ-004 SHALL have parameter BASE, default 0, DPRAM base address of the 64-entry block.
REQ-005 SHALL have ports: CLOCK_50_I in 1 clock; Reset in 1 reset (one clock; reset is synchronous and active-high).
REQ-006 SHALL have ports: blk_start in 1 start pulse; q_sel in 1 Q-matrix select; coef_valid in 1; coef_value in IN_W signed; coef_run in 6 zeros preceding value; coef_eob in 1 zero-fill to block end; coef_ready out 1.
REQ-007 SHALL have ports: ram_address out RAM_AW; ram_write_data out 32; ram_we out 1; busy out 1; blk_done out 1 one-cycle pulse; err out 1 sticky overflow flag.

Function
REQ-008 SHALL implement states IDLE, WAIT, ZERO, WRITE, FILL, DONE.
REQ-009 SHALL move IDLE->WAIT on blk_start, latching q_sel, clearing zigzag index k to 0 and clearing err; SHALL ignore blk_start outside IDLE.
REQ-010 SHALL assert coef_ready only in WAIT; a token SHALL be accepted on a cycle with coef_valid=1 and coef_ready=1, and SHALL be accepted exactly once.
REQ-011 On acceptance, SHALL latch value and run: eob=1 -> FILL, value ignored; run>0 -> ZERO; run=0 -> WRITE.
REQ-012 ZERO SHALL write 0 at one index k per cycle for run cycles, then enter WRITE.
REQ-013 WRITE SHALL write the dequantized value at index k for one cycle, then enter WAIT, or DONE if k=63.
REQ-014 FILL SHALL write 0 at one index per cycle from current k through 63 inclusive, then enter DONE.
REQ-015 DONE SHALL pulse blk_done for one cycle, then return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-016 Outputs SHALL be registered: for a token accepted on cycle N, its first ram_we=1 SHALL appear on cycle N+1.
REQ-017 ram_address SHALL be BASE plus the row-major position of zigzag index k, using the standard 8x8 order 0,1,8,16,9,2,3,10,17,24,... ending 55,62,63.
REQ-018 k SHALL increment after every write.
REQ-019 Dequantized value SHALL be coef_value arithmetically left-shifted by the table shift. The table is indexed by diagonal d = row + column of the position.
REQ-020 For q_sel=0, the shift for d=0..14 SHALL be 3,2,3,3,4,4,5,5,6,6,6,6,6,6,6.
REQ-021 For q_sel=1, the shift for d=0..14 SHALL be 3,1,1,1,2,2,3,3,4,4,4,5,5,5,5.
REQ-022 ram_write_data SHALL be the COEF_W result sign-extended to 32 bits; ram_we SHALL be 0 in IDLE, WAIT and DONE.
REQ-023 Overflow: if a run would push k past 63, ZERO SHALL stop after writing index 63, the value SHALL be dropped, err SHALL set, and the block SHALL enter DONE.
REQ-024 err SHALL hold until the next accepted blk_start or Reset.

Reset
REQ-025 While Reset=1 on a clock edge, the block SHALL enter IDLE with k=0, all of ram_address, ram_write_data, ram_we, busy, blk_done, err and coef_ready at 0.
REQ-026 Reset asserted mid-block SHALL abandon the block without any further write; the next blk_start SHALL restart at k=0.

Configuration
REQ-027 With macro M3DQ_SAT_EN defined, a dequantized value outside the COEF_W signed range SHALL saturate to the range limit before sign extension.
REQ-028 Without M3DQ_SAT_EN, the result SHALL be truncated to its low COEF_W bits (two's-complement wrap).

Verification
REQ-029 Single value: q_sel=0, token (5, run 0), then eob -> addr 0 data 40, then 63 zero writes in zigzag order ending at addr 63, followed by one blk_done pulse.
REQ-030 Runs and sign: q_sel=1, tokens (-3, run 0) and (7, run 2) -> addr0=0xFFFFFFE8, addr1=0, addr8=0, addr16=14.
REQ-031 Overflow: token (1, run 0), then (9, run 63) -> zeros at k=1..63, 9 never written, err=1, blk_done pulses.
REQ-032 Saturation, COEF_W=12, q_sel=0: value 255 at k=63 -> 0x000007FF with M3DQ_SAT_EN; 0xFFFFFFC0 without.
REQ-033 Backpressure: coef_valid held high through a run-5 ZERO phase -> coef_ready=0 throughout and the token is written exactly once.
REQ-034 Reset after 10 writes -> ram_we=0 and busy=0 on the next cycle; a new blk_start writes addr BASE+0 first.
